// File: rtl/hc_csr_bank.sv
// MMIO control/status register bank for HardCloud AFUs: DSM base, control FSM,
// and NUM_BUFFERS buffer descriptors with read-back, locking and legality checks.
module hc_csr_bank #(
  parameter int unsigned NUM_BUFFERS   = 2,
  parameter logic [15:0] DSM_ADDR      = 16'h110,
  parameter logic [15:0] CONTROL_ADDR  = 16'h118,
  parameter logic [15:0] STATUS_ADDR   = 16'h100,
  parameter logic [15:0] BUF_BASE_ADDR = 16'h120
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      mmio_wr_valid,
  input  logic                      mmio_rd_valid,
  input  logic [15:0]               mmio_addr,
  input  logic [8:0]                mmio_tid,
  input  logic [63:0]               mmio_wdata,
  output logic                      mmio_rsp_valid,
  output logic [8:0]                mmio_rsp_tid,
  output logic [63:0]               mmio_rsp_data,
  output logic [63:0]               dsm_base,
  output logic [64*NUM_BUFFERS-1:0] buf_addr,
  output logic [32*NUM_BUFFERS-1:0] buf_size,
  output logic [NUM_BUFFERS-1:0]    buf_valid,
  input  logic                      core_done,
  output logic                      core_rst_n,
  output logic                      core_run,
  output logic                      core_start,
  output logic [1:0]                state,
  output logic                      err
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_IDLE  = 2'd1,
    S_RUN   = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  localparam logic [31:0] CMD_ASSERT_RST   = 32'h0;
  localparam logic [31:0] CMD_DEASSERT_RST = 32'h1;
  localparam logic [31:0] CMD_START        = 32'h3;
  localparam logic [31:0] CMD_STOP         = 32'h7;

  localparam logic [17:0] DSM_B     = 18'(DSM_ADDR);
  localparam logic [17:0] CTRL_B    = 18'(CONTROL_ADDR);
  localparam logic [17:0] STATUS_B  = 18'(STATUS_ADDR);
  localparam logic [17:0] BUF_B     = 18'(BUF_BASE_ADDR);
  localparam logic [17:0] BUF_END_B = 18'(BUF_BASE_ADDR + 16 * NUM_BUFFERS);

  state_e      state_q, state_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        start_q, start_d;
  logic [63:0] dsm_q, dsm_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [63:0] addr_q [NUM_BUFFERS];
  logic [63:0] addr_d [NUM_BUFFERS];
  logic [31:0] size_q [NUM_BUFFERS];
  logic [31:0] size_d [NUM_BUFFERS];
  logic        rspValid_q;
  logic [8:0]  rspTid_q;
  logic [63:0] rspData_q;

  logic [17:0]            byteOff;
  logic [13:0]            bufIdx;
  logic                   aligned;
  logic                   hitDsm, hitCtrl, hitStatus, hitBuf;
  logic                   ctrlAssert;
  logic [NUM_BUFFERS-1:0] bufValid;
  logic [63:0]            statusWord;
  logic [63:0]            rdData;

  assign byteOff    = {mmio_addr, 2'b00};
  assign bufIdx     = 14'((byteOff - BUF_B) >> 4);
  assign aligned    = ~mmio_addr[0];
  assign hitDsm     = aligned && (byteOff == DSM_B);
  assign hitCtrl    = aligned && (byteOff == CTRL_B);
  assign hitStatus  = aligned && (byteOff == STATUS_B);
  assign hitBuf     = aligned && (byteOff >= BUF_B) && (byteOff < BUF_END_B);
  assign ctrlAssert = mmio_wr_valid && hitCtrl && (mmio_wdata[31:0] == CMD_ASSERT_RST);

  for (genvar g = 0; g < NUM_BUFFERS; g++) begin : gBuf
    assign bufValid[g]           = (addr_q[g] != 64'h0) && (size_q[g] != 32'h0);
    assign buf_addr[64*g +: 64]  = addr_q[g];
    assign buf_size[32*g +: 32]  = size_q[g];
  end

  assign statusWord = {32'h0, 16'(bufValid), 8'(NUM_BUFFERS), 4'h0, done_q, err_q, state_q};

  // Write decode, control FSM and completion handling; an ASSERT_RST write beats core_done.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    done_d  = done_q;
    dsm_d   = dsm_q;
    ctrl_d  = ctrl_q;
    addr_d  = addr_q;
    size_d  = size_q;

    if (mmio_wr_valid) begin
      if (hitDsm) begin
        if (state_q == S_RUN) err_d = 1'b1;
        else                  dsm_d = {mmio_wdata[63:6], 6'b0};
      end

      if (hitCtrl) begin
        ctrl_d = mmio_wdata[31:0];
        case (mmio_wdata[31:0])
          CMD_ASSERT_RST: begin
            state_d = S_RESET;
            err_d   = 1'b0;
            done_d  = 1'b0;
          end
          CMD_DEASSERT_RST: begin
            if (state_q == S_RESET || state_q == S_STOP) state_d = S_IDLE;
            else                                         err_d   = 1'b1;
          end
          CMD_START: begin
            if (state_q == S_IDLE) state_d = S_RUN;
            else                   err_d   = 1'b1;
          end
          CMD_STOP: begin
            if (state_q == S_RUN) state_d = S_STOP;
            else                  err_d   = 1'b1;
          end
          default: err_d = 1'b1;
        endcase
      end

      if (hitBuf) begin
        if (state_q == S_RUN) begin
          err_d = 1'b1;
        end else begin
          for (int i = 0; i < int'(NUM_BUFFERS); i++) begin
            if (bufIdx == 14'(i)) begin
              if (byteOff[3]) size_d[i] = mmio_wdata[31:0];
              else            addr_d[i] = {mmio_wdata[63:6], 6'b0};
            end
          end
        end
      end
    end

    if (core_done && state_q == S_RUN && !ctrlAssert) begin
      state_d = S_STOP;
      done_d  = 1'b1;
    end
  end

  assign start_d = (state_d == S_RUN) && (state_q != S_RUN);

  // Read mux sees only registered values, so a same-cycle write is not visible.
  always_comb begin
    rdData = 64'h0;
    if (hitStatus) begin
      rdData = statusWord;
    end else if (hitDsm) begin
      rdData = dsm_q;
    end else if (hitCtrl) begin
      rdData = {32'h0, ctrl_q};
    end else if (hitBuf) begin
      for (int i = 0; i < int'(NUM_BUFFERS); i++) begin
        if (bufIdx == 14'(i)) rdData = byteOff[3] ? {32'h0, size_q[i]} : addr_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_RESET;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      start_q    <= 1'b0;
      dsm_q      <= 64'h0;
      ctrl_q     <= 32'h0;
      rspValid_q <= 1'b0;
      rspTid_q   <= 9'h0;
      rspData_q  <= 64'h0;
      for (int i = 0; i < int'(NUM_BUFFERS); i++) begin
        addr_q[i] <= 64'h0;
        size_q[i] <= 32'h0;
      end
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      done_q     <= done_d;
      start_q    <= start_d;
      dsm_q      <= dsm_d;
      ctrl_q     <= ctrl_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      rspValid_q <= mmio_rd_valid;
      if (mmio_rd_valid) begin
        rspTid_q  <= mmio_tid;
        rspData_q <= rdData;
      end
    end
  end

  assign mmio_rsp_valid = rspValid_q;
  assign mmio_rsp_tid   = rspTid_q;
  assign mmio_rsp_data  = rspData_q;
  assign dsm_base       = dsm_q;
  assign buf_valid      = bufValid;
  assign core_rst_n     = (state_q != S_RESET);
  assign core_run       = (state_q == S_RUN);
  assign core_start     = start_q;
  assign state          = state_q;
  assign err            = err_q;

endmodule
